// File: rtl/pc_defs.sv
// Shared definitions for the program counter with return-address stack:
// default parameter values and the operation chosen each cycle.
package pc_defs;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_RESET_ADDR = 0;

  // One operation per cycle. OP_OVF / OP_UNF are rejected call / return
  // attempts: they only raise a sticky flag and leave PC and stack alone.
  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LOAD   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_OVF    = 3'd6,
    OP_UNF    = 3'd7
  } pc_op_e;

  // Priority: ret > call > load > branch > inc > hold. A rejected ret/call
  // still wins priority, so lower strobes in that cycle are dropped.
  function automatic pc_op_e decode_op(input logic ret,
                                       input logic call,
                                       input logic load,
                                       input logic branch,
                                       input logic inc,
                                       input logic full,
                                       input logic empty);
    if (ret)    return empty ? OP_UNF : OP_RET;
    if (call)   return full  ? OP_OVF : OP_CALL;
    if (load)   return OP_LOAD;
    if (branch) return OP_BRANCH;
    if (inc)    return OP_INC;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// LIFO of return addresses. Push and pop are never requested together by
// the top level; an illegal push (full) or pop (empty) is ignored here.
module ret_addr_stack
  import pc_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  // Low bits of the count address the next free slot; the top entry sits
  // one below it (wraps correctly because DEPTH is a power of two).
  assign wr_idx  = count_q[AW-1:0];
  assign rd_idx  = wr_idx - 1'b1;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign top_o   = mem_q[rd_idx];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next entry count.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    count_d = count_q;
    if (do_push)     count_d = count_q + 1'b1;
    else if (do_pop) count_d = count_q - 1'b1;
  end

  // Entry count register; reset discards every pending return address.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; an empty count makes stale entries unreachable.
    if (do_push) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/prog_counter_stack.sv
// Program counter with increment, absolute load, relative branch and
// call/return through a return-address stack. All outputs are registered.
module prog_counter_stack
  import pc_defs::*;
#(
  parameter int              WIDTH      = DEF_WIDTH,
  parameter int              DEPTH      = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR)
) (
  input  logic             p_Clock,
  input  logic             p_Reset,
  input  logic             p_IncPC,
  input  logic             p_Load,
  input  logic             p_Branch,
  input  logic             p_Call,
  input  logic             p_Ret,
  input  logic [WIDTH-1:0] p_DataIn,
  input  logic [WIDTH-1:0] p_Offset,
  output logic [WIDTH-1:0] p_Output,
  output logic             p_StackEmpty,
  output logic             p_StackFull,
  output logic             p_Overflow,
  output logic             p_Underflow
);

  localparam int CW = $clog2(DEPTH + 1);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stk_top;
  logic [CW-1:0]    stk_count;
  logic             stk_full;
  logic             stk_empty;

  assign op = decode_op(p_Ret, p_Call, p_Load, p_Branch, p_IncPC,
                        stk_full, stk_empty);

  ret_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk_i   (p_Clock),
    .rst_i   (p_Reset),
    .push_i  (op == OP_CALL),
    .pop_i   (op == OP_RET),
    .data_i  (pc_q + 1'b1),
    .top_o   (stk_top),
    .count_o (stk_count),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Next PC and sticky error flags from the decoded operation; all
  // arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    unique case (op)
      OP_INC:    pc_d = pc_q + 1'b1;
      OP_BRANCH: pc_d = pc_q + p_Offset;
      OP_LOAD:   pc_d = p_DataIn;
      OP_CALL:   pc_d = p_DataIn;
      OP_RET:    pc_d = stk_top;
      OP_OVF:    ovf_d = 1'b1;
      OP_UNF:    unf_d = 1'b1;
      default:   pc_d = pc_q;
    endcase
  end

  // PC and flag registers; reset overrides every strobe.
  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack occupancy must stay within 0..DEPTH and never read full and empty.
  always_ff @(posedge p_Clock) begin
    if (!p_Reset) begin
      assert (stk_count <= CW'(DEPTH));
      assert (!(stk_full && stk_empty));
    end
  end

  assign p_Output     = pc_q;
  assign p_StackEmpty = stk_empty;
  assign p_StackFull  = stk_full;
  assign p_Overflow   = ovf_q;
  assign p_Underflow  = unf_q;

endmodule

// File: tb/tb_prog_counter_stack.sv
// Self-checking bench: directed vector table, then randomized strobes
// compared against a queue-based reference model.
module tb_prog_counter_stack;

  localparam int W     = 16;
  localparam int D     = 4;
  localparam int NRAND = 2000;

  logic         clk = 1'b0;
  logic         rst, inc, load, branch, call, ret;
  logic [W-1:0] data, offset;
  logic [W-1:0] pc_out;
  logic         empty, full, ovf, unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_counter_stack #(
    .WIDTH      (W),
    .DEPTH      (D),
    .RESET_ADDR (16'h0000)
  ) dut (
    .p_Clock      (clk),
    .p_Reset      (rst),
    .p_IncPC      (inc),
    .p_Load       (load),
    .p_Branch     (branch),
    .p_Call       (call),
    .p_Ret        (ret),
    .p_DataIn     (data),
    .p_Offset     (offset),
    .p_Output     (pc_out),
    .p_StackEmpty (empty),
    .p_StackFull  (full),
    .p_Overflow   (ovf),
    .p_Underflow  (unf)
  );

  typedef struct {
    logic         rst, inc, load, branch, call, ret;
    logic [W-1:0] data, offset;
    logic [W-1:0] pc;
    logic         empty, full, ovf, unf;
    string        name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, i, l, b, c, t,
                     input logic [W-1:0] d, o, p,
                     input logic e, f, ov, un, input string nm);
    vec_t v;
    v.rst = r; v.inc = i; v.load = l; v.branch = b; v.call = c; v.ret = t;
    v.data = d; v.offset = o; v.pc = p;
    v.empty = e; v.full = f; v.ovf = ov; v.unf = un; v.name = nm;
    vq.push_back(v);
  endtask

  // Drive one cycle of strobes, let the edge happen, sample 1 time unit later.
  task automatic step(input logic r, i, l, b, c, t, input logic [W-1:0] d, o);
    rst = r; inc = i; load = l; branch = b; call = c; ret = t;
    data = d; offset = o;
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_ovf, m_unf;

  initial begin
    step(1, 0, 0, 0, 0, 0, '0, '0);

    //  rst inc ld br cl rt data      offset    pc       E F O U
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, "reset");
    add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 0, 0, "inc1");
    add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0, "inc2");
    add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 1, 0, 0, 0, "inc3");
    add(0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0, 0, 0, "load_ffff");
    add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, "inc_wrap");
    add(0, 0, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 1, 0, 0, 0, "load_10");
    add(0, 0, 0, 1, 0, 0, 16'h0000, 16'hFFF0, 16'h0000, 1, 0, 0, 0, "branch_neg");
    add(0, 0, 1, 0, 0, 0, 16'h0005, 16'h0000, 16'h0005, 1, 0, 0, 0, "load_5");
    add(0, 0, 0, 0, 1, 0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0, 0, "call_100");
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0006, 1, 0, 0, 0, "ret_6");
    add(0, 0, 0, 0, 1, 0, 16'h1000, 16'h0000, 16'h1000, 0, 0, 0, 0, "nest1");
    add(0, 0, 0, 0, 1, 0, 16'h2000, 16'h0000, 16'h2000, 0, 0, 0, 0, "nest2");
    add(0, 0, 0, 0, 1, 0, 16'h3000, 16'h0000, 16'h3000, 0, 0, 0, 0, "nest3");
    add(0, 0, 0, 0, 1, 0, 16'h4000, 16'h0000, 16'h4000, 0, 1, 0, 0, "nest4_full");
    add(0, 0, 0, 0, 1, 0, 16'h0200, 16'h0000, 16'h4000, 0, 1, 1, 0, "call_overflow");
    add(0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h3001, 0, 0, 1, 0, "unwind1");
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h2001, 0, 0, 1, 0, "unwind2");
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h1001, 0, 0, 1, 0, "unwind3");
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0007, 1, 0, 1, 0, "unwind4");
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, "reset_clr_ovf");
    add(0, 0, 1, 0, 0, 0, 16'h0007, 16'h0000, 16'h0007, 1, 0, 0, 0, "load_7");
    add(0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0007, 1, 0, 0, 1, "ret_underflow");
    add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 0, 0, 1, "unf_sticky");
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, "reset_clr_unf");
    add(0, 0, 1, 0, 0, 0, 16'h0050, 16'h0000, 16'h0050, 1, 0, 0, 0, "load_50");
    add(0, 0, 0, 0, 1, 0, 16'h0600, 16'h0000, 16'h0600, 0, 0, 0, 0, "call_600");
    add(0, 0, 1, 0, 1, 1, 16'h0999, 16'h0000, 16'h0051, 1, 0, 0, 0, "ret_beats_call_load");
    add(1, 1, 1, 1, 1, 1, 16'h0999, 16'h0003, 16'h0000, 1, 0, 0, 0, "reset_all_strobes");
    add(0, 0, 0, 0, 1, 0, 16'h0300, 16'h0000, 16'h0300, 0, 0, 0, 0, "call_300");
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, "reset_mid_call");
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, "ret_after_reset");
    add(0, 1, 1, 1, 0, 0, 16'h1234, 16'h0005, 16'h1234, 1, 0, 0, 1, "load_beats_branch");
    add(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0005, 16'h1239, 1, 0, 0, 1, "branch_beats_inc");
    add(0, 0, 0, 0, 0, 0, 16'hABCD, 16'h0005, 16'h1239, 1, 0, 0, 1, "hold");

    foreach (vq[k]) begin
      step(vq[k].rst, vq[k].inc, vq[k].load, vq[k].branch, vq[k].call, vq[k].ret,
           vq[k].data, vq[k].offset);
      check({vq[k].name, ".pc"},    32'(pc_out), 32'(vq[k].pc));
      check({vq[k].name, ".empty"}, 32'(empty),  32'(vq[k].empty));
      check({vq[k].name, ".full"},  32'(full),   32'(vq[k].full));
      check({vq[k].name, ".ovf"},   32'(ovf),    32'(vq[k].ovf));
      check({vq[k].name, ".unf"},   32'(unf),    32'(vq[k].unf));
    end

    // Randomized phase: start from a known reset, then mirror in the model.
    step(1, 0, 0, 0, 0, 0, '0, '0);
    m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    for (int n = 0; n < NRAND; n++) begin
      logic         r, i, l, b, c, t;
      logic [W-1:0] d, o;
      r = ($urandom_range(63) == 0);
      i = ($urandom_range(1) == 0);
      l = ($urandom_range(7) == 0);
      b = ($urandom_range(5) == 0);
      c = ($urandom_range(3) == 0);
      t = ($urandom_range(3) == 0);
      d = W'($urandom);
      o = W'($urandom);
      step(r, i, l, b, c, t, d, o);

      if (r) begin
        m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (t) begin
        if (m_stk.size() == 0) m_unf = 1;
        else m_pc = m_stk.pop_back();
      end else if (c) begin
        if (m_stk.size() == D) m_ovf = 1;
        else begin
          m_stk.push_back(m_pc + 16'd1);
          m_pc = d;
        end
      end else if (l) m_pc = d;
      else if (b)     m_pc = m_pc + o;
      else if (i)     m_pc = m_pc + 16'd1;

      check("rand.pc",    32'(pc_out), 32'(m_pc));
      check("rand.empty", 32'(empty),  32'(m_stk.size() == 0));
      check("rand.full",  32'(full),   32'(m_stk.size() == D));
      check("rand.ovf",   32'(ovf),    32'(m_ovf));
      check("rand.unf",   32'(unf),    32'(m_unf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
